// File: rtl/alu_result_queue.sv
// Result queue behind the ALU result select: derives overflow/compare flags at push
// and buffers entries in a DEPTH-entry FIFO. Optional macro: ALU_RESULT_STICKY_OVF_EN.
module alu_result_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [31:0]      in_result,
  input  logic [31:0]      in_operand_a,
  input  logic [31:0]      in_operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_opcode,
  output logic [31:0]      out_result,
  output logic             out_ovf,
  output logic             out_ne,
  output logic             out_lt,
  output logic [CNT_W-1:0] count
`ifdef ALU_RESULT_STICKY_OVF_EN
  ,
  input  logic             ovf_clear,
  output logic             ovf_sticky
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [31:0] result;
    logic        ovf;
    logic        ne;
    logic        lt;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           entry_in;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;
  logic             is_add;
  logic             is_sub;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  assign is_add = (in_opcode[2:0] == 3'b000);
  assign is_sub = (in_opcode[2:0] == 3'b001);

  always_comb begin
    entry_in        = '0;
    entry_in.opcode = in_opcode;
    entry_in.result = in_result;
    if (is_add)
      entry_in.ovf = (in_operand_a[31] == in_operand_b[31]) && (in_result[31] != in_operand_a[31]);
    else if (is_sub)
      entry_in.ovf = (in_operand_a[31] != in_operand_b[31]) && (in_result[31] != in_operand_a[31]);
    else
      entry_in.ovf = 1'b0;
    entry_in.ne = (in_operand_a != in_operand_b);
    entry_in.lt = is_sub & (in_result[31] ^ entry_in.ovf);
  end

  // Storage needs no reset: the head is gated to zero whenever the queue is empty.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    head = '0;
    if (out_valid)
      head = mem[rd_ptr];
  end

  assign out_opcode = head.opcode;
  assign out_result = head.result;
  assign out_ovf    = head.ovf;
  assign out_ne     = head.ne;
  assign out_lt     = head.lt;

`ifdef ALU_RESULT_STICKY_OVF_EN
  // A set in the same cycle as a clear takes priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      ovf_sticky <= 1'b0;
    else if (pop && head.ovf)
      ovf_sticky <= 1'b1;
    else if (ovf_clear)
      ovf_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Scoreboard bench for alu_result_queue: directed vectors with hand-computed flags;
// a negedge monitor compares the head against the expected queue.
module tb_alu_result_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_opcode;
  logic [31:0]      in_result;
  logic [31:0]      in_operand_a;
  logic [31:0]      in_operand_b;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_opcode;
  logic [31:0]      out_result;
  logic             out_ovf;
  logic             out_ne;
  logic             out_lt;
  logic [CNT_W-1:0] count;
`ifdef ALU_RESULT_STICKY_OVF_EN
  logic             ovf_clear;
  logic             ovf_sticky;
`endif

  alu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_result    (in_result),
    .in_operand_a (in_operand_a),
    .in_operand_b (in_operand_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_result   (out_result),
    .out_ovf      (out_ovf),
    .out_ne       (out_ne),
    .out_lt       (out_lt),
    .count        (count)
`ifdef ALU_RESULT_STICKY_OVF_EN
    ,
    .ovf_clear    (ovf_clear),
    .ovf_sticky   (ovf_sticky)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [31:0] result;
    logic        ovf;
    logic        ne;
    logic        lt;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected occupancy is the scoreboard depth; the push is recorded once the edge has passed.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic e_ovf, input logic e_ne, input logic e_lt);
    logic accept;
    exp_t e;
    in_valid     = 1'b1;
    in_opcode    = op;
    in_operand_a = a;
    in_operand_b = b;
    in_result    = r;
    accept       = (sb.size() < DEPTH);
    chk("in_ready", 64'(in_ready), 64'(accept));
    e = '{opcode: op, result: r, ovf: e_ovf, ne: e_ne, lt: e_lt};
    step();
    if (accept)
      sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk("drain_count", 64'(count), 64'(0));
    chk("drain_out_valid", 64'(out_valid), 64'(0));
  endtask

  // Monitor: head must match the oldest expected entry (and hold while stalled).
  always @(negedge clock) begin
    if (reset_n) begin
      if (sb.size() != 0) begin
        chk("head", {23'd0, out_valid, out_opcode, out_result, out_ovf, out_ne, out_lt},
            {23'd0, 1'b1, sb[0]});
        if (out_ready)
          void'(sb.pop_front());
      end else begin
        chk("empty_head", {23'd0, out_valid, out_opcode, out_result, out_ovf, out_ne, out_lt},
            64'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    in_opcode    = '0;
    in_result    = '0;
    in_operand_a = '0;
    in_operand_b = '0;
    out_ready    = 1'b0;
`ifdef ALU_RESULT_STICKY_OVF_EN
    ovf_clear    = 1'b0;
`endif
    step();
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    reset_n = 1'b1;
    step();

    // Add overflow, visible one cycle after the push.
    out_ready = 1'b1;
    issue(5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    chk("latency_out_valid", 64'(out_valid), 64'(1));
    chk("latency_out_result", 64'(out_result), 64'h8000_0000);
    // Sub compares, sub overflow, non-arith op, upper opcode bits ignored for decode.
    issue(5'b00001, 32'hFFFF_FFFB, 32'h0000_0003, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1);
    issue(5'b00001, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    issue(5'b00001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    issue(5'b00010, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    issue(5'b11000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    issue(5'b00011, 32'h0000_0005, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b1, 1'b0);
    drain();

    // Fill with backpressure: fifth push must be refused.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      issue(5'b00010, 32'(i), 32'(i + 1), 32'(i), 1'b0, 1'b1, 1'b0);
    chk("full_count", 64'(count), 64'(4));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    step();
    drain();

    // Steady push+pop at occupancy 2 across pointer wraps.
    out_ready = 1'b0;
    issue(5'b00100, 32'h10, 32'h10, 32'h100, 1'b0, 1'b0, 1'b0);
    issue(5'b00100, 32'h11, 32'h10, 32'h101, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b1;
    for (int i = 2; i < 22; i++) begin
      issue(5'b00100, 32'(i), 32'h5, 32'(32'h100 + i), 1'b0, (i != 5), 1'b0);
      chk("steady_count", 64'(count), 64'(2));
    end
    drain();

    // Asynchronous reset mid-stream with three entries buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(5'b00001, 32'h9, 32'(i), 32'(9 - i), 1'b0, 1'b1, 1'b0);
    chk("pre_rst_count", 64'(count), 64'(3));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'(0));
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_in_ready", 64'(in_ready), 64'(1));
    chk("async_rst_out_result", 64'(out_result), 64'(0));
    sb.delete();
    step();
    reset_n = 1'b1;
    step();

`ifdef ALU_RESULT_STICKY_OVF_EN
    chk("sticky_rst", 64'(ovf_sticky), 64'(0));
    out_ready = 1'b1;
    issue(5'b00000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    chk("sticky_before_pop", 64'(ovf_sticky), 64'(0));
    step();
    chk("sticky_set", 64'(ovf_sticky), 64'(1));
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    chk("sticky_clear", 64'(ovf_sticky), 64'(0));
    issue(5'b00000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    chk("sticky_set_wins", 64'(ovf_sticky), 64'(1));
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
